// File: rtl/compare_nbit_seq_pkg.sv
// Shared definitions for the digit-serial magnitude comparator:
// FSM state encoding and the one-hot {lt,gt,eq} result encoding.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vector layout is {lt, gt, eq}.
  typedef logic [2:0] res_t;

  localparam res_t RES_LT   = 3'b100;
  localparam res_t RES_GT   = 3'b010;
  localparam res_t RES_EQ   = 3'b001;
  localparam res_t RES_NONE = 3'b000;

endpackage : compare_pkg

// File: rtl/compare_nbit_seq_digit.sv
// compare_digit: combinational unsigned compare of one DIGIT-bit digit pair,
// producing a one-hot {lt,gt,eq} result.
module compare_digit
  import compare_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output res_t             o_res
);

  // Exactly one result bit is high for any input pair.
  assign o_res = (i_a < i_b) ? RES_LT :
                 (i_a > i_b) ? RES_GT : RES_EQ;

endmodule : compare_digit

// File: rtl/compare_nbit_seq.sv
// compare_nbit_seq: digit-serial WIDTH-bit magnitude comparator, MSB digit
// first, signed or unsigned, with valid/ready handshakes on both sides.
// Optional build macro CMP_EARLY_EXIT_EN: when defined, RUN ends on the first
// differing digit instead of always scanning all NDIG digits. Results are
// identical in both builds; only latency differs.
module compare_nbit_seq
  import compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_found;    // a differing digit has already been seen
  res_t             r_res;      // result of the first differing digit
  res_t             r_out_res;  // registered {lt,gt,eq}
  logic             r_out_valid;

  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  res_t             w_cmp_res;
  res_t             w_sel_res;
  logic             w_last;
  logic             w_leave_run;

  // Select digit r_idx of both captured operands for the shared comparator.
  always_comb begin
    // NOTE: defaults before the loop keep this block free of inferred latches.
    w_dig_a = '0;
    w_dig_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_dig_a = r_a[i*DIGIT +: DIGIT];
        w_dig_b = r_b[i*DIGIT +: DIGIT];
      end
    end
  end

  compare_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a   (w_dig_a),
    .i_b   (w_dig_b),
    .o_res (w_cmp_res)
  );

  // The first non-equal digit decides; later digits cannot change the answer.
  assign w_sel_res = r_found ? r_res : w_cmp_res;
  assign w_last    = (r_idx == '0);

`ifdef CMP_EARLY_EXIT_EN
  assign w_leave_run = w_last || (w_cmp_res != RES_EQ);
`else
  assign w_leave_run = w_last;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign lt        = r_out_res[2];
  assign gt        = r_out_res[1];
  assign eq        = r_out_res[0];

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= IDX_TOP;
      r_found     <= 1'b0;
      r_res       <= RES_EQ;
      r_out_res   <= RES_NONE;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // signed_mode only matters here: after the sign-bit flip the
            // whole compare is unsigned, so it need not be kept.
            r_a     <= signed_mode ? (a ^ MSB_MASK) : a;
            r_b     <= signed_mode ? (b ^ MSB_MASK) : b;
            r_idx   <= IDX_TOP;
            r_found <= 1'b0;
            r_res   <= RES_EQ;
            r_state <= RUN;
          end
        end

        RUN: begin
          if (w_leave_run) begin
            r_out_res   <= w_sel_res;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            if (!r_found && (w_cmp_res != RES_EQ)) begin
              r_found <= 1'b1;
              r_res   <= w_cmp_res;
            end
            r_idx <= r_idx - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_res   <= RES_NONE;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_res   <= RES_NONE;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule : compare_nbit_seq
